// File: rtl/crc_engine_param_if.sv
// Handshake and status bundle for crc_engine_param.
// errCnt/errCntClr are present only when CRC_ERR_CNT_EN is defined.
interface crc_engine_param_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             checkMode;
  logic             din;
  logic             shiftEn;
  logic             endPacket;
  logic             clear;
  logic             doutReady;
  logic             dout;
  logic             doutValid;
  logic [WIDTH-1:0] crc;
  logic             busy;
  logic             crcOk;
  logic             crcErr;
  logic             done;
`ifdef CRC_ERR_CNT_EN
  logic             errCntClr;
  logic [7:0]       errCnt;
`endif

  modport master (
    output start, checkMode, din, shiftEn, endPacket, clear, doutReady,
    input  dout, doutValid, crc, busy, crcOk, crcErr, done
`ifdef CRC_ERR_CNT_EN
    , output errCntClr, input errCnt
`endif
  );

  modport slave (
    input  start, checkMode, din, shiftEn, endPacket, clear, doutReady,
    output dout, doutValid, crc, busy, crcOk, crcErr, done
`ifdef CRC_ERR_CNT_EN
    , input errCntClr, output errCnt
`endif
  );
endinterface

// File: rtl/crc_engine_param.sv
// Bit-serial CRC generator/checker for the USB packet path (CRC5 tokens, CRC16 data).
// Optional saturating error counter enabled by defining CRC_ERR_CNT_EN.
module crc_engine_param #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(32'h0000_8005),
  parameter logic [WIDTH-1:0] INIT       = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESIDUE    = WIDTH'(32'h0000_800D),
  parameter bit               INVERT_OUT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  crc_engine_param_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam int         CW      = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             fb_s;
  logic [WIDTH-1:0] acc_crc_s;

  // CRC value including this cycle's data bit, if one is offered
  always_comb begin
    fb_s = bus.din ^ crc_q[WIDTH-1];
    if (bus.shiftEn) begin
      acc_crc_s = {crc_q[WIDTH-2:0], 1'b0} ^ (fb_s ? POLY : {WIDTH{1'b0}});
    end else begin
      acc_crc_s = crc_q;
    end
  end

  // Sequencing: clear beats start, start beats the per-state behaviour
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    crc_d   = crc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.clear) begin
      state_d = S_IDLE;
      crc_d   = INIT;
      out_d   = {WIDTH{1'b0}};
      cnt_d   = {CW{1'b0}};
    end else if (bus.start) begin
      state_d = S_ACCUM;
      mode_d  = bus.checkMode;
      crc_d   = INIT;
      out_d   = {WIDTH{1'b0}};
      cnt_d   = {CW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ACCUM: begin
          crc_d = acc_crc_s;
          if (bus.endPacket) begin
            if (mode_q) begin
              state_d = S_IDLE;
              ok_d    = (acc_crc_s == RESIDUE);
              err_d   = (acc_crc_s != RESIDUE);
            end else begin
              state_d = S_SHIFT;
              out_d   = INVERT_OUT ? ~acc_crc_s : acc_crc_s;
              cnt_d   = {CW{1'b0}};
            end
          end else begin
            state_d = S_ACCUM;
          end
        end
        S_SHIFT: begin
          // crc_q is frozen here; only the out shifter moves on acceptance
          if (bus.doutReady) begin
            out_d = {out_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_SHIFT;
            end
          end else begin
            state_d = S_SHIFT;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      crc_q   <= INIT;
      out_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      crc_q   <= crc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign bus.dout      = out_q[WIDTH-1];
  assign bus.doutValid = (state_q == S_SHIFT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.crc       = crc_q;
  assign bus.crcOk     = ok_q;
  assign bus.crcErr    = err_q;
  assign bus.done      = done_q;

`ifdef CRC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts crcErr pulses, saturating; a same-cycle clear wins
  always_comb begin
    if (bus.errCntClr) begin
      err_cnt_d = 8'h00;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.errCnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_engine_param.sv
// Scoreboard bench for crc_engine_param: a WIDTH=16 and a WIDTH=5 instance driven with
// random packets; expected events come from a polynomial-division reference model.
module tb_crc_engine_param;

  localparam int EV_BIT  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_OK   = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int   kind;
    logic val;
    bit   last;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  crc_engine_param_if #(.WIDTH(16)) b16 ();
  crc_engine_param_if #(.WIDTH(5))  b5 ();

  crc_engine_param #(
    .WIDTH(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUE(16'h800D), .INVERT_OUT(1'b1)
  ) u16 (.clk(clk), .rst(rst), .bus(b16));

  crc_engine_param #(
    .WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C), .INVERT_OUT(1'b1)
  ) u5 (.clk(clk), .rst(rst), .bus(b5));

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  ev_t         exp_q[2][$];
  int          rdy_mode[2];
  bit          tog[2];
  bit          stall_p[2];
  bit          abort_p[2];
  bit          last_p[2];
  logic        dout_p[2];
  int          done_seen[2];
  int          ok_seen[2];
  int          err_seen[2];
  bit          clr_on_pulse = 1'b0;
  int          W[2]     = '{16, 5};
  logic [31:0] POLYV[2] = '{32'h8005, 32'h05};
  logic [31:0] INITV[2] = '{32'hFFFF, 32'h1F};
  logic [31:0] RESV[2]  = '{32'h800D, 32'h0C};

  // Remainder of (INIT*x^n + M(x)*x^w) mod G by long division, first bit = highest term
  function automatic logic [31:0] crc_ref(int w, logic [31:0] poly, logic [31:0] init, bit bits[$]);
    int n;
    bit c[];
    logic [31:0] r;
    n = bits.size();
    c = new[n + w];
    for (int i = 0; i < n; i++) c[n - 1 - i + w] = bits[i];
    for (int k = 0; k < w; k++) c[k + n] ^= init[k];
    for (int j = n + w - 1; j >= w; j--) begin
      if (c[j]) begin
        c[j] = 1'b0;
        for (int k = 0; k < w; k++) c[j - w + k] ^= poly[k];
      end
    end
    r = 32'h0;
    for (int k = 0; k < w; k++) r[k] = c[k];
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_crc(int d);
    return (d == 0) ? {16'h0000, b16.crc} : {27'h0, b5.crc};
  endfunction

  function automatic logic get_busy(int d);
    return (d == 0) ? b16.busy : b5.busy;
  endfunction

  task automatic set_in(int d, logic s, logic m, logic di, logic se, logic ep, logic cl);
    if (d == 0) begin
      b16.start = s; b16.checkMode = m; b16.din = di; b16.shiftEn = se; b16.endPacket = ep; b16.clear = cl;
    end else begin
      b5.start = s; b5.checkMode = m; b5.din = di; b5.shiftEn = se; b5.endPacket = ep; b5.clear = cl;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop(int d, int kind, logic val, output bit lst);
    ev_t e;
    lst = 1'b0;
    if (exp_q[d].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut%0d: got event kind %0d, required none", d, kind);
      return;
    end
    e = exp_q[d].pop_front();
    chk($sformatf("event_kind_dut%0d", d), kind, e.kind);
    if (kind == EV_BIT) chk($sformatf("dout_bit_dut%0d", d), {31'h0, val}, {31'h0, e.val});
    lst = e.last;
  endtask

  task automatic mon(int d, logic v, logic r, logic o, logic dn, logic ok, logic er, logic ab);
    bit lst;
    lst = 1'b0;
    if (rst) begin
      stall_p[d] = 1'b0; abort_p[d] = 1'b0; last_p[d] = 1'b0;
      return;
    end
    if (stall_p[d] && !abort_p[d]) begin
      chk($sformatf("stall_valid_dut%0d", d), {31'h0, v}, 32'h1);
      chk($sformatf("stall_dout_dut%0d", d), {31'h0, o}, {31'h0, dout_p[d]});
    end
    if (dn || ok || er) chk($sformatf("pulse_onehot_dut%0d", d), $countones({dn, ok, er}), 32'h1);
    if (dn) begin
      done_seen[d]++;
      chk($sformatf("done_after_last_dut%0d", d), {31'h0, last_p[d]}, 32'h1);
      pop(d, EV_DONE, 1'b0, lst);
    end
    if (ok) begin ok_seen[d]++;  pop(d, EV_OK, 1'b0, lst);  end
    if (er) begin err_seen[d]++; pop(d, EV_ERR, 1'b0, lst); end
    lst = 1'b0;
    if (v && r) pop(d, EV_BIT, o, lst);
    stall_p[d] = v && !r;
    dout_p[d]  = o;
    abort_p[d] = ab;
    last_p[d]  = lst;
  endtask

  // Monitor: samples both DUTs mid-cycle and retires scoreboard entries
  always @(negedge clk) begin
    mon(0, b16.doutValid, b16.doutReady, b16.dout, b16.done, b16.crcOk, b16.crcErr, b16.start | b16.clear);
    mon(1, b5.doutValid, b5.doutReady, b5.dout, b5.done, b5.crcOk, b5.crcErr, b5.start | b5.clear);
  end

  // Downstream ready pattern per DUT: 0 always, 1 toggling, 2 random, 3 never
  initial begin
    b16.doutReady = 1'b1;
    b5.doutReady  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic r;
        case (rdy_mode[d])
          0: r = 1'b1;
          1: begin tog[d] = ~tog[d]; r = tog[d]; end
          2: r = 1'($urandom_range(1));
          default: r = 1'b0;
        endcase
        if (d == 0) b16.doutReady = r; else b5.doutReady = r;
      end
    end
  end

  task automatic send(int d, bit mode, bit bits[$], output logic [31:0] fin);
    int n;
    int i;
    int w;
    int budget;
    bit se;
    bit ep;
    bit ended;
    ev_t e;
    n = bits.size();
    i = 0;
    w = W[d];
    ended = 1'b0;
    fin = crc_ref(w, POLYV[d], INITV[d], bits);
    set_in(d, 1'b1, mode, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    while (!ended) begin
      se = (i < n) && ($urandom_range(3) != 0);
      ep = (i == n) || (se && (i == n - 1) && ($urandom_range(1) == 1));
      set_in(d, 1'b0, 1'($urandom_range(1)), se ? bits[i] : 1'($urandom_range(1)), se, ep, 1'b0);
      if (ep) begin
        if (!mode) begin
          for (int k = w - 1; k >= 0; k--) begin
            e.kind = EV_BIT; e.val = ~fin[k]; e.last = (k == 0);
            exp_q[d].push_back(e);
          end
          e.kind = EV_DONE; e.val = 1'b0; e.last = 1'b0;
          exp_q[d].push_back(e);
        end else begin
          e.kind = (fin == RESV[d]) ? EV_OK : EV_ERR; e.val = 1'b0; e.last = 1'b0;
          exp_q[d].push_back(e);
        end
      end
      ended = ep;
      if (se) i++;
      step();
    end
    set_in(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CRC_ERR_CNT_EN
    if (clr_on_pulse) begin
      b5.errCntClr = 1'b1;
      step();
      b5.errCntClr = 1'b0;
    end
`endif
    budget = 0;
    while (exp_q[d].size() != 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q[d].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout dut%0d: %0d events pending, required 0", d, exp_q[d].size());
      exp_q[d].delete();
    end
    @(negedge clk);
    chk($sformatf("busy_after_dut%0d", d), {31'h0, get_busy(d)}, 32'h0);
    chk($sformatf("crc_final_dut%0d", d), get_crc(d), fin);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] fin;
    logic [31:0] fin2;
    bit          bits[$];
    bit          data[$];
    logic [7:0]  byte_v;
    logic [6:0]  addr;
    logic [3:0]  endp;
    int          d;
    int          n;
    bit          mode;
    int          base;

    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CRC_ERR_CNT_EN
    b16.errCntClr = 1'b0;
    b5.errCntClr  = 1'b0;
`endif
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy_dut%0d", k), {31'h0, get_busy(k)}, 32'h0);
      chk($sformatf("rst_crc_dut%0d", k), get_crc(k), INITV[k]);
    end
    chk("rst_valid_dut0", {31'h0, b16.doutValid}, 32'h0);
    chk("rst_pulses_dut0", {29'h0, b16.done, b16.crcOk, b16.crcErr}, 32'h0);
    chk("rst_dout_dut0", {31'h0, b16.dout}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty generate packet: sixteen zeros then done, crc stays all ones
    bits.delete();
    base = done_seen[0];
    send(0, 1'b0, bits, fin);
    chk("empty_gen_crc", get_crc(0), 32'hFFFF);
    chk("empty_gen_done", done_seen[0] - base, 32'h1);

    // USB token vectors; the DUT holds the pre-inversion value of the emitted CRC5
    addr = 7'h15; endp = 4'hE; bits.delete();
    for (int k = 0; k < 7; k++) bits.push_back(addr[k]);
    for (int k = 0; k < 4; k++) bits.push_back(endp[k]);
    send(1, 1'b0, bits, fin);
    chk("crc5_tok_15_e", get_crc(1), 32'h08);
    addr = 7'h3A; endp = 4'hA; bits.delete();
    for (int k = 0; k < 7; k++) bits.push_back(addr[k]);
    for (int k = 0; k < 4; k++) bits.push_back(endp[k]);
    send(1, 1'b0, bits, fin);
    chk("crc5_tok_3a_a", get_crc(1), 32'h03);

    // CRC16 loopback over bytes 00 01 02 03
    data.delete();
    for (int b = 0; b < 4; b++) begin
      byte_v = 8'(b);
      for (int k = 0; k < 8; k++) data.push_back(byte_v[k]);
    end
    send(0, 1'b0, data, fin);
    bits = data;
    for (int k = 15; k >= 0; k--) bits.push_back(~fin[k]);
    base = ok_seen[0];
    send(0, 1'b1, bits, fin2);
    chk("loop_residue", get_crc(0), 32'h800D);
    chk("loop_ok_pulse", ok_seen[0] - base, 32'h1);
    bits[5] = ~bits[5];
    base = err_seen[0];
    send(0, 1'b1, bits, fin2);
    chk("loop_flip_err_pulse", err_seen[0] - base, 32'h1);

    // Toggling ready: every bit held while stalled, exactly sixteen transfers
    rdy_mode[0] = 1;
    data.delete();
    repeat (24) data.push_back(1'($urandom_range(1)));
    send(0, 1'b0, data, fin);
    rdy_mode[0] = 0;

    // clear mid-ACCUM, then start mid-SHIFT_OUT with no transfers accepted
    rdy_mode[0] = 3;
    base = done_seen[0] + ok_seen[0] + err_seen[0];
    step();
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      set_in(0, 1'b0, 1'b0, 1'($urandom_range(1)), 1'b1, 1'b0, 1'b0);
      step();
    end
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("clear_busy", {31'h0, b16.busy}, 32'h0);
    chk("clear_crc", get_crc(0), 32'hFFFF);
    @(posedge clk);
    #1;
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("shift_valid", {31'h0, b16.doutValid}, 32'h1);
    @(posedge clk);
    #1;
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("restart_busy", {31'h0, b16.busy}, 32'h1);
    chk("restart_valid", {31'h0, b16.doutValid}, 32'h0);
    chk("restart_crc", get_crc(0), 32'hFFFF);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_idle", {31'h0, b16.busy}, 32'h0);
    chk("abort_no_pulse", done_seen[0] + ok_seen[0] + err_seen[0] - base, 32'h0);
    rdy_mode[0] = 0;

    // Random packets on both widths, random ready, half of checks carry a valid CRC
    rdy_mode[0] = 2;
    rdy_mode[1] = 2;
    repeat (40) begin
      d = $urandom_range(1);
      n = $urandom_range(40);
      mode = 1'($urandom_range(1));
      data.delete();
      repeat (n) data.push_back(1'($urandom_range(1)));
      if (mode && ($urandom_range(1) == 1)) begin
        fin = crc_ref(W[d], POLYV[d], INITV[d], data);
        for (int k = W[d] - 1; k >= 0; k--) data.push_back(~fin[k]);
      end
      send(d, mode, data, fin);
    end
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;

`ifdef CRC_ERR_CNT_EN
    repeat (300) begin
      do begin
        data.delete();
        repeat (3) data.push_back(1'($urandom_range(1)));
      end while (crc_ref(5, 32'h05, 32'h1F, data) == 32'h0C);
      send(1, 1'b1, data, fin);
    end
    chk("errcnt_saturate", {24'h0, b5.errCnt}, 32'hFF);
    clr_on_pulse = 1'b1;
    do begin
      data.delete();
      repeat (3) data.push_back(1'($urandom_range(1)));
    end while (crc_ref(5, 32'h05, 32'h1F, data) == 32'h0C);
    send(1, 1'b1, data, fin);
    clr_on_pulse = 1'b0;
    chk("errcnt_clear_wins", {24'h0, b5.errCnt}, 32'h0);
`endif

    chk("queue_empty_dut0", exp_q[0].size(), 32'h0);
    chk("queue_empty_dut1", exp_q[1].size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
